// File: rtl/en_ext_mem_bridge.sv
// en_ext_mem_bridge
//   Bridge between the ElectronNest external load/store ports and a
//   single-port synchronous SRAM (one-cycle read latency).
//   - Boot: emits BOOT_PAD zero tokens (first one a=1), then streams
//     BOOT_LEN words from BOOT_BASE through the normal read path.
//   - RUN: load addresses queue in an address FIFO, read data lands in a
//     response FIFO presented first-word fall-through on O_Ld_FTk; stores
//     are written straight through and take priority over read issue.
// Ports
//   clock, reset      : clock, synchronous active-high reset
//   I_Boot            : boot start pulse (honoured in IDLE only)
//   I_Ld_Req/Addr     : fabric load request and address
//   O_Ld_FTk/I_Ld_BTk : load data token out / back token in (n = nack)
//   I_St_Req/Addr/FTk : fabric store request, address, data token
//   O_St_BTk          : store back token (n = 1 outside RUN)
//   O_Mem_*/I_Mem_RData : SRAM strobe, write enable, address, data
//   O_Busy, O_Err     : activity indicator, sticky protocol error

package en_pkg;
    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_EXADDR = 16;

    typedef struct packed {
        logic                    v;
        logic                    a;
        logic                    r;
        logic                    c;
        logic [WIDTH_DATA-1:0]   d;
        logic [WIDTH_EXADDR-1:0] i;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

module en_ext_mem_bridge #(
    parameter int WIDTH_DATA   = en_pkg::WIDTH_DATA,
    parameter int WIDTH_EXADDR = en_pkg::WIDTH_EXADDR,
    parameter int BOOT_PAD     = 3,
    parameter int BOOT_LEN     = 5,
    parameter int BOOT_BASE    = 0,
    parameter int DEPTH        = 4,
    parameter bit INDEX_EN     = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    input  logic                    I_Ld_Req,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
    output en_pkg::FTk_t            O_Ld_FTk,
    input  en_pkg::BTk_t            I_Ld_BTk,
    input  logic                    I_St_Req,
    input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
    input  en_pkg::FTk_t            I_St_FTk,
    output en_pkg::BTk_t            O_St_BTk,
    output logic                    O_Mem_Req,
    output logic                    O_Mem_We,
    output logic [WIDTH_EXADDR-1:0] O_Mem_Addr,
    output logic [WIDTH_DATA-1:0]   O_Mem_WData,
    input  logic [WIDTH_DATA-1:0]   I_Mem_RData,
    output logic                    O_Busy,
    output logic                    O_Err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (BOOT_PAD > 1) ? $clog2(BOOT_PAD) : 1;
    localparam int LW = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BOOT_PAD, S_BOOT_LOAD, S_RUN} state_t;
    state_t state, state_nx;

    logic [PW-1:0] pad_cnt;
    logic [LW-1:0] bt_cnt;

    // address FIFO
    logic [WIDTH_EXADDR-1:0] af_mem [DEPTH];
    logic [AW-1:0]           af_wp, af_rp;
    logic [AW:0]             af_cnt;
    // response FIFO
    en_pkg::FTk_t            rf_mem [DEPTH];
    logic [AW-1:0]           rf_wp, rf_rp;
    logic [AW:0]             rf_cnt;
    en_pkg::FTk_t            rf_din;
    // read in flight (data arrives next cycle)
    logic                    rd_pend;
    logic [WIDTH_EXADDR-1:0] rd_addr;
    logic                    err;

    logic st_nack, st_acc, pad_push, pad_last, boot_rd, credit_ok;
    logic rd_issue, af_push, af_pop, rf_push, rf_pop, err_set;
    logic [WIDTH_EXADDR-1:0] rd_issue_addr;

    assign st_nack  = (state != S_RUN);
    assign st_acc   = I_St_Req & I_St_FTk.v & ~st_nack;
    assign pad_push = (state == S_BOOT_PAD) && (rf_cnt != FULL);
    assign pad_last = pad_push && (pad_cnt == PW'(BOOT_PAD - 1));
    // The first boot read overlaps the last pad push so boot words follow
    // the pads without a bubble.
    assign boot_rd  = (state == S_BOOT_LOAD) || pad_last;
    // Reserve a response slot for everything already committed to arrive.
    assign credit_ok = (32'(rf_cnt) + 32'(rd_pend) + 32'(pad_push)) < 32'(DEPTH);
    assign rd_issue  = ~st_acc & credit_ok &
                       (boot_rd | ((state == S_RUN) && (af_cnt != '0)));
    assign rd_issue_addr = boot_rd ? WIDTH_EXADDR'(BOOT_BASE) + WIDTH_EXADDR'(bt_cnt)
                                   : af_mem[af_rp];
    assign af_pop   = rd_issue & (state == S_RUN);
    assign af_push  = I_Ld_Req & (state == S_RUN) & ((af_cnt != FULL) | af_pop);
    assign err_set  = I_Ld_Req & ~af_push;
    assign rf_push  = pad_push | rd_pend;
    assign rf_pop   = (rf_cnt != '0) & ~I_Ld_BTk.n;

    always_comb begin
        rf_din   = '0;
        rf_din.v = 1'b1;
        if (pad_push) begin
            rf_din.a = (pad_cnt == '0);
        end else begin
            rf_din.d = I_Mem_RData;
            rf_din.i = INDEX_EN ? rd_addr : '0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (I_Boot) state_nx = S_BOOT_PAD;
            S_BOOT_PAD:  if (pad_last)
                             state_nx = (rd_issue && BOOT_LEN == 1) ? S_RUN : S_BOOT_LOAD;
            S_BOOT_LOAD: if (rd_issue && bt_cnt == LW'(BOOT_LEN - 1)) state_nx = S_RUN;
            default:     state_nx = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            pad_cnt <= '0;
            bt_cnt  <= '0;
            af_wp   <= '0;
            af_rp   <= '0;
            af_cnt  <= '0;
            rf_wp   <= '0;
            rf_rp   <= '0;
            rf_cnt  <= '0;
            rd_pend <= 1'b0;
            rd_addr <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            if (pad_push)            pad_cnt <= pad_cnt + 1'b1;
            if (rd_issue && boot_rd) bt_cnt  <= bt_cnt + 1'b1;
            if (af_push) af_wp <= af_wp + 1'b1;
            if (af_pop)  af_rp <= af_rp + 1'b1;
            af_cnt  <= af_cnt + (AW+1)'(af_push) - (AW+1)'(af_pop);
            if (rf_push) rf_wp <= rf_wp + 1'b1;
            if (rf_pop)  rf_rp <= rf_rp + 1'b1;
            rf_cnt  <= rf_cnt + (AW+1)'(rf_push) - (AW+1)'(rf_pop);
            rd_pend <= rd_issue;
            rd_addr <= rd_issue_addr;
            err     <= err | err_set;
        end
    end

    // storage arrays carry no reset; occupancy is tracked by the counters
    always_ff @(posedge clock) begin
        if (af_push) af_mem[af_wp] <= I_Ld_Addr;
        if (rf_push) rf_mem[rf_wp] <= rf_din;
    end

    always_comb begin
        O_Ld_FTk   = (rf_cnt != '0) ? rf_mem[rf_rp] : '0;
        O_St_BTk   = '0;
        // back token reads all-zero while reset is held, nack otherwise
        O_St_BTk.n = st_nack & ~reset;
    end

    assign O_Mem_Req   = st_acc | rd_issue;
    assign O_Mem_We    = st_acc;
    assign O_Mem_Addr  = st_acc ? I_St_Addr : (rd_issue ? rd_issue_addr : '0);
    assign O_Mem_WData = st_acc ? I_St_FTk.d : '0;
    assign O_Busy      = (state == S_BOOT_PAD) || (state == S_BOOT_LOAD) ||
                         (af_cnt != '0) || (rf_cnt != '0) || rd_pend;
    assign O_Err       = err;

    logic unused_bits;
    assign unused_bits = ^{I_Ld_BTk.t, I_Ld_BTk.v, I_Ld_BTk.c,
                           I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i};

endmodule

// File: tb/tb_en_ext_mem_bridge.sv
// Scoreboard bench for en_ext_mem_bridge: a behavioural SRAM answers the
// bridge, expected load tokens are queued as stimulus is applied and
// compared as the bridge hands them over.
module tb_en_ext_mem_bridge;

    localparam bit IDX = 1'b1;

    logic                clock = 1'b0;
    logic                reset;
    logic                I_Boot, I_Ld_Req, I_St_Req;
    logic [15:0]         I_Ld_Addr, I_St_Addr;
    en_pkg::FTk_t        O_Ld_FTk, I_St_FTk;
    en_pkg::BTk_t        I_Ld_BTk, O_St_BTk;
    logic                O_Mem_Req, O_Mem_We, O_Busy, O_Err;
    logic [15:0]         O_Mem_Addr;
    logic [31:0]         O_Mem_WData, I_Mem_RData;

    logic                pre_we;
    logic [7:0]          pre_addr;
    logic [31:0]         pre_data;
    logic [31:0]         mem [0:255];

    en_pkg::FTk_t        sb [$];
    en_pkg::FTk_t        exp_tok;
    int                  n_vec = 0;
    int                  n_miss = 0;

    en_ext_mem_bridge #(.INDEX_EN(IDX)) dut (
        .clock(clock), .reset(reset), .I_Boot(I_Boot),
        .I_Ld_Req(I_Ld_Req), .I_Ld_Addr(I_Ld_Addr), .O_Ld_FTk(O_Ld_FTk),
        .I_Ld_BTk(I_Ld_BTk), .I_St_Req(I_St_Req), .I_St_Addr(I_St_Addr),
        .I_St_FTk(I_St_FTk), .O_St_BTk(O_St_BTk), .O_Mem_Req(O_Mem_Req),
        .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr), .O_Mem_WData(O_Mem_WData),
        .I_Mem_RData(I_Mem_RData), .O_Busy(O_Busy), .O_Err(O_Err)
    );

    always #5 clock = ~clock;

    // behavioural SRAM, one-cycle read latency; pre_* preloads contents
    always @(posedge clock) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (O_Mem_Req) begin
            if (O_Mem_We) mem[O_Mem_Addr[7:0]] <= O_Mem_WData;
            else          I_Mem_RData <= mem[O_Mem_Addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic en_pkg::FTk_t mk(input logic [31:0] d, input logic a,
                                         input logic [15:0] addr);
        en_pkg::FTk_t t;
        t   = '0;
        t.v = 1'b1;
        t.a = a;
        t.d = d;
        t.i = IDX ? addr : 16'h0;
        return t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic push_boot();
        for (int p = 0; p < 3; p++) sb.push_back(mk(32'h0, p == 0, 16'h0));
        for (int k = 0; k < 5; k++) sb.push_back(mk(32'h11 * (k + 1), 1'b0, 16'(k)));
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300 && (sb.size() != 0 || O_Busy); k++) tick();
        chk({tag, "_sb_left"}, 64'(sb.size()), 64'h0);
        chk({tag, "_busy"}, 64'(O_Busy), 64'h0);
    endtask

    // consumer side: every handed-over token must match the scoreboard head
    always @(negedge clock) begin
        if (!reset && O_Ld_FTk.v && !I_Ld_BTk.n) begin
            if (sb.size() == 0)
                chk("extra_tok", 64'(O_Ld_FTk.v), 64'h0);
            else begin
                exp_tok = sb.pop_front();
                chk("ld_tok", 64'(O_Ld_FTk), 64'(exp_tok));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; I_Boot = 0; I_Ld_Req = 0; I_Ld_Addr = '0; I_Ld_BTk = '0;
        I_St_Req = 0; I_St_Addr = '0; I_St_FTk = '0; pre_we = 0; pre_addr = '0;
        pre_data = '0; I_Mem_RData = '0;
        tick(); tick();
        for (int k = 0; k < 5; k++)  poke(8'(k), 32'h11 * (k + 1));
        poke(8'h20, 32'hDEAD);
        poke(8'h30, 32'h1234);
        for (int k = 0; k < 4; k++)  poke(8'h40 + 8'(k), 32'h4000 + k);
        for (int k = 0; k < 10; k++) poke(8'h50 + 8'(k), 32'hA000 + k);

        // reset state
        @(negedge clock);
        chk("rst_ftk", 64'(O_Ld_FTk), 64'h0);
        chk("rst_stbtk", 64'(O_St_BTk), 64'h0);
        chk("rst_memreq", 64'(O_Mem_Req), 64'h0);
        chk("rst_busy", 64'(O_Busy), 64'h0);
        chk("rst_err", 64'(O_Err), 64'h0);
        tick(); reset = 1'b0;
        @(negedge clock);
        chk("idle_st_nack", 64'(O_St_BTk.n), 64'h1);

        // boot: pads then boot words, contiguous
        tick();
        push_boot();
        I_Boot = 1'b1;
        tick(); I_Boot = 1'b0;
        @(negedge clock);
        chk("boot_early", 64'(O_Ld_FTk.v), 64'h0);
        tick(); @(negedge clock);
        chk("boot_first_a", 64'({O_Ld_FTk.v, O_Ld_FTk.a}), 64'h3);
        chk("boot_st_nack", 64'(O_St_BTk.n), 64'h1);
        for (int k = 1; k < 8; k++) begin
            tick(); @(negedge clock);
            chk("boot_contig", 64'(O_Ld_FTk.v), 64'h1);
        end
        tick(); @(negedge clock);
        chk("boot_end", 64'(O_Ld_FTk.v), 64'h0);
        wait_drain("boot");
        chk("run_st_ack", 64'(O_St_BTk.n), 64'h0);

        // single unloaded load, latency t+3
        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h20;
        sb.push_back(mk(32'hDEAD, 1'b0, 16'h20));
        tick(); I_Ld_Req = 1'b0;
        @(negedge clock);
        chk("ld_strobe", 64'({O_Mem_Req, O_Mem_We, O_Mem_Addr}), 64'({2'b10, 16'h20}));
        tick(); @(negedge clock);
        chk("ld_early", 64'(O_Ld_FTk.v), 64'h0);
        tick(); @(negedge clock);
        chk("ld_lat3", 64'(O_Ld_FTk.v), 64'h1);
        wait_drain("ld");

        // store and load to same address: write first, read deferred a cycle
        I_St_Req = 1'b1; I_St_Addr = 16'h30; I_St_FTk = mk(32'hBEEF, 1'b0, 16'h0);
        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h30;
        sb.push_back(mk(32'hBEEF, 1'b0, 16'h30));
        tick(); I_Ld_Req = 1'b0;
        @(negedge clock);
        chk("st_prio", 64'({O_Mem_Req, O_Mem_We, O_Mem_Addr}), 64'({2'b11, 16'h30}));
        tick(); I_St_Req = 1'b0; I_St_FTk = '0;
        @(negedge clock);
        chk("rd_deferred", 64'({O_Mem_Req, O_Mem_We, O_Mem_Addr}), 64'({2'b10, 16'h30}));
        tick(); @(negedge clock);
        chk("raw_early", 64'(O_Ld_FTk.v), 64'h0);
        tick(); @(negedge clock);
        chk("raw_lat4", 64'(O_Ld_FTk.v), 64'h1);
        wait_drain("raw");

        // four loads under nack: head held, then 1/cycle drain
        I_Ld_BTk.n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            I_Ld_Req = 1'b1; I_Ld_Addr = 16'h40 + 16'(k);
            sb.push_back(mk(32'h4000 + k, 1'b0, 16'h40 + 16'(k)));
            tick();
        end
        I_Ld_Req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("nack_head", 64'(O_Ld_FTk.d), 64'h4000);
            tick();
        end
        I_Ld_BTk.n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("drain_rate", 64'(O_Ld_FTk.v), 64'h1);
            tick();
        end
        @(negedge clock);
        chk("drain_done", 64'(O_Ld_FTk.v), 64'h0);
        tick();

        // overflow: 10 loads under nack, only 8 fit (4 addr + 4 resp)
        I_Ld_BTk.n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            I_Ld_Req = 1'b1; I_Ld_Addr = 16'h50 + 16'(k);
            if (k < 8) sb.push_back(mk(32'hA000 + k, 1'b0, 16'h50 + 16'(k)));
            tick();
            if (k == 7) chk("no_err_yet", 64'(O_Err), 64'h0);
        end
        I_Ld_Req = 1'b0;
        chk("ovf_err", 64'(O_Err), 64'h1);
        @(negedge clock);
        chk("ovf_head", 64'(O_Ld_FTk.d), 64'hA000);
        tick();
        I_Ld_BTk.n = 1'b0;
        wait_drain("ovf");

        // reset clears error
        reset = 1'b1; tick();
        @(negedge clock);
        chk("rst_err_clr", 64'(O_Err), 64'h0);
        tick(); reset = 1'b0;

        // reset during BOOT_LOAD
        tick();
        push_boot();
        I_Boot = 1'b1;
        tick(); I_Boot = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("midrst_ftk", 64'(O_Ld_FTk), 64'h0);
        chk("midrst_stbtk", 64'(O_St_BTk), 64'h0);
        chk("midrst_mem", 64'({O_Mem_Req, O_Mem_We, O_Mem_Addr, O_Mem_WData}), 64'h0);
        chk("midrst_busy", 64'(O_Busy), 64'h0);
        sb.delete();
        tick(); reset = 1'b0;
        @(negedge clock);
        chk("midrst_idle", 64'({O_St_BTk.n, O_Busy}), 64'h2);

        // load outside RUN is an error and is ignored
        tick();
        I_Ld_Req = 1'b1; I_Ld_Addr = 16'h20;
        tick(); I_Ld_Req = 1'b0;
        chk("idle_ld_err", 64'({O_Err, O_Busy}), 64'h2);
        reset = 1'b1; tick(); reset = 1'b0;

        // re-boot gives the full sequence again
        push_boot();
        I_Boot = 1'b1;
        tick(); I_Boot = 1'b0;
        wait_drain("reboot");
        chk("reboot_run", 64'({O_St_BTk.n, O_Err}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
